uvmt_axis_st_dut_fifo: RTL
==========================

// Module: uvmt_axis_st_dut_fifo
//
// PURPOSE
//   AXI4-Stream synchronous FIFO used as the self-test DUT between the master and slave uvma_axis_if agents.
//   Accepts beats on the s_* port (driven by the master agent) and replays them in order on the m_* port
//   (consumed by the slave agent).
//   Buffers beats to decouple backpressure. The DUT checker compares both interfaces against this spec.
//
// PARAMETERS
//   DATA_WIDTH  64  tdata width in bits; multiple of 8
//   USER_WIDTH  1   tuser width in bits; >= 1
//   DEPTH       8   storage entries; power of 2, >= 2
//
// PORTS
//   clk          in   1                    clock; all logic on rising edge
//   reset_n      in   1                    asynchronous, active-low reset
//   s_tvalid     in   1                    upstream beat valid
//   s_tready     out  1                    FIFO can accept a beat
//   s_tdata      in   DATA_WIDTH           upstream data
//   s_tkeep      in   DATA_WIDTH/8         upstream byte qualifiers
//   s_tlast      in   1                    upstream end of packet
//   s_tuser      in   USER_WIDTH           upstream sideband
//   m_tvalid     out  1                    downstream beat valid
//   m_tready     in   1                    downstream ready
//   m_tdata      out  DATA_WIDTH           downstream data
//   m_tkeep      out  DATA_WIDTH/8         downstream byte qualifiers
//   m_tlast      out  1                    downstream end of packet
//   m_tuser      out  USER_WIDTH           downstream sideband
//   level        out  $clog2(DEPTH)+1      number of beats stored
//
// BEHAVIOUR
//   - Reset (reset_n=0, async) sets all of the following.
//     - Pointers, level and packet count = 0.
//     - m_tvalid=0 and m_tdata/m_tkeep/m_tlast/m_tuser=0.
//     - s_tready=0 while reset_n=0; s_tready goes to 1 on the first clk edge after deassertion.
//   - Reset mid-operation flushes all stored beats. No beat is emitted after reset.
//   - Push when s_tvalid && s_tready. Pop when m_tvalid && m_tready. Both can occur in the same cycle.
//   - Pointers are $clog2(DEPTH)+1 bits. Each pointer wraps naturally at 2*DEPTH.
//   - full = (level==DEPTH); empty = (level==0).
//   - s_tready = !full, registered. A simultaneous pop does NOT admit a push into a full FIFO.
//   - Simultaneous push and pop when neither full nor empty: level unchanged, both beats transfer.
//   - Latency: a beat pushed at edge N is presented on m_* after edge N+1 (registered output) when the FIFO
//     was empty. Bypass of the output register is not allowed.
//   - Output stage is a holding register refilled from storage on pop or when it is empty.
//     - level counts storage plus the holding register.
//     - A beat sitting in the holding register still counts toward full.
//   - AXI rule: once m_tvalid=1, m_t* stay stable until m_tready=1. m_tvalid never depends combinationally
//     on m_tready.
//   - tkeep, tlast and tuser are carried unmodified. Null beats (tkeep=0) are stored like any other beat.
//   - Ordering is strictly FIFO; no beat is dropped or duplicated.
//
// CONFIGURATION
//   UVMT_AXIS_ST_DUT_FIFO_PKT_MODE_EN
//   - Undefined (cut-through):
//     - m_tvalid=1 whenever the holding register has a beat.
//   - Defined (store-and-forward):
//     - pkt_cnt counts stored beats with tlast=1.
//       - +1 on a push with tlast; -1 on a pop with tlast; unchanged when both occur in one cycle.
//     - The holding register is loaded only while pkt_cnt>0 or full.
//     - Full escape: a full FIFO holding no tlast drains in cut-through until it pops a tlast beat.
//       This prevents deadlock on packets longer than DEPTH.
//     - pkt_cnt resets to 0.
//
// TESTING
//   - Reset then idle: after reset_n rises, next edge s_tready=1, m_tvalid=0, level=0.
//   - Single beat: push tdata=64'hA5A5_0000_0000_0001, tlast=1 with m_tready=1.
//     m_tvalid rises exactly 1 cycle later with identical fields, then level returns to 0.
//   - Fill/full: m_tready=0, push 8 beats 0..7.
//     s_tready=0 after the 8th beat with level=8.
//     A 9th beat holding s_tvalid is not accepted.
//     Then m_tready=1 drains 0..7 in order.
//   - Streaming: s_tvalid=1 and m_tready=1 for 100 beats.
//     After the first beat, throughput is 1 beat/cycle and level stays constant.
//   - Reset mid-stream: assert reset_n=0 with level=5.
//     m_tvalid drops immediately (async) and level=0.
//     Post-reset, only newly pushed beats appear.
//   - PKT_MODE_EN: push 3-beat packet with m_tready=1.
//     m_tvalid stays 0 until the cycle after the tlast push.
//     A 12-beat packet with DEPTH=8 still completes via the full escape.

Source files
------------

// File: rtl/uvmt_axis_st_dut_fifo.sv
// AXI4-Stream synchronous FIFO with a registered output holding stage.
// Define UVMT_AXIS_ST_DUT_FIFO_PKT_MODE_EN for store-and-forward packet mode.
module uvmt_axis_st_dut_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tlast,
  output logic [USER_WIDTH-1:0]     m_tuser,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = DATA_WIDTH + KW + 1 + USER_WIDTH;

  logic [BW-1:0] mem_p0 [DEPTH];
  logic [PW-1:0] wptr_p0, rptr_p0, wptr_nxt, rptr_nxt, lvl_nxt;
  logic          vld_p1, vld_nxt;
  logic          push, pop, load, stor_ne, load_ok;

  assign push     = s_tvalid && s_tready;
  assign pop      = vld_p1 && m_tready;
  assign stor_ne  = (wptr_p0 != rptr_p0);
  assign load     = stor_ne && (!vld_p1 || pop) && load_ok;
  assign m_tvalid = vld_p1;
  assign level    = (wptr_p0 - rptr_p0) + PW'(vld_p1);

  always_comb begin
    wptr_nxt = wptr_p0 + PW'(push);
    rptr_nxt = rptr_p0 + PW'(load);
    vld_nxt  = load || (vld_p1 && !pop);
    lvl_nxt  = (wptr_nxt - rptr_nxt) + PW'(vld_nxt);
  end

`ifdef UVMT_AXIS_ST_DUT_FIFO_PKT_MODE_EN
  logic [PW-1:0] pkt_cnt;
  logic          esc, full, pkt_pend;

  assign full     = (level == PW'(DEPTH));
  // A tlast already sitting in the holding stage does not release the beats behind it.
  assign pkt_pend = (pkt_cnt - PW'(vld_p1 && m_tlast)) != '0;
  assign load_ok  = pkt_pend || full || esc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
      esc     <= 1'b0;
    end else begin
      pkt_cnt <= pkt_cnt + PW'(push && s_tlast) - PW'(pop && m_tlast);
      if (pop && m_tlast)
        esc <= 1'b0;
      else if (full && pkt_cnt == '0)
        esc <= 1'b1;
    end
  end
`else
  assign load_ok = 1'b1;
`endif

  // Stage p0: storage write
  always_ff @(posedge clk) begin
    if (push)
      mem_p0[wptr_p0[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast, s_tuser};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_p0  <= '0;
      rptr_p0  <= '0;
      vld_p1   <= 1'b0;
      s_tready <= 1'b0;
    end else begin
      wptr_p0  <= wptr_nxt;
      rptr_p0  <= rptr_nxt;
      vld_p1   <= vld_nxt;
      s_tready <= (lvl_nxt != PW'(DEPTH));
    end
  end

  // Stage p1: output holding register, refilled from storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tdata <= '0;
      m_tkeep <= '0;
      m_tlast <= 1'b0;
      m_tuser <= '0;
    end else if (load) begin
      {m_tdata, m_tkeep, m_tlast, m_tuser} <= mem_p0[rptr_p0[AW-1:0]];
    end
  end
endmodule
